gpr_writeback: RTL and testbench

- Write-side front end of the integer register file; the sole producer of its write port (`rd`, `wEn`, `wData`).
- Merges single-cycle ALU results with long-latency LSU/MUL results, buffering the latter in a small FIFO.
- Drives one registered write per cycle.
- Keeps a pending-write scoreboard so issue logic can stall on operands whose results have not yet been written back.

---
 rtl/gpr_wb_pkg.sv | 30 +++
 rtl/wb_fifo.sv | 75 +++++++
 rtl/gpr_writeback.sv | 170 +++++++++++++++++
 tb/tb_gpr_writeback.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_wb_pkg.sv
// Shared types for the integer register-file write-back front end.
// Optional macro GPR_WB_FWD_EN enables the write-cycle bypass outputs in gpr_writeback.
package gpr_wb_pkg;

    // Architectural register file geometry
    localparam int unsigned REG_COUNT = 32;
    localparam int unsigned REG_IDX_W = 5;

    // Result data width carried through the LSU buffer
    localparam int unsigned WB_DATA_W = 64;

    // Which producer owns the write port in a given cycle
    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_ALU  = 2'd1,
        WB_SRC_LSU  = 2'd2
    } wb_src_e;

    // One buffered long-latency result
    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    // x0 is hardwired zero, so a write to it is consumed without effect
    function automatic logic is_real_dest(input logic [REG_IDX_W-1:0] rd);
        return rd != '0;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back entries buffering LSU/MUL results.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module wb_fifo
    import gpr_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  wb_entry_t        wdata,
    input  logic             pop,
    output wb_entry_t        head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Guard against overrun/underrun so a misbehaving caller cannot corrupt state
    always_comb begin
        do_push  = push && (count_q != CNT_W'(DEPTH));
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Simultaneous push and pop leaves the occupancy unchanged
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy state, cleared immediately on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/gpr_writeback.sv
// Write-side front end of the integer register file: merges ALU results with buffered
// LSU results, drives one registered write per cycle and tracks pending long-latency writes.
// Optional macro GPR_WB_FWD_EN adds fwd1_hit/fwd2_hit/fwd_data bypass outputs.
// ARCH_WIDTH is expected to match gpr_wb_pkg::WB_DATA_W, the width of buffered entries.
module gpr_writeback
    import gpr_wb_pkg::*;
#(
    parameter int unsigned ARCH_WIDTH = WB_DATA_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // Single-cycle ALU results
    input  logic                  alu_valid,
    input  logic [REG_IDX_W-1:0]  alu_rd,
    input  logic [ARCH_WIDTH-1:0] alu_data,
    output logic                  alu_stall,
    // Long-latency LSU/MUL results
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_IDX_W-1:0]  lsu_rd,
    input  logic [ARCH_WIDTH-1:0] lsu_data,
    // Scoreboard set and query
    input  logic                  issue_valid,
    input  logic [REG_IDX_W-1:0]  issue_rd,
    input  logic [REG_IDX_W-1:0]  rs1,
    input  logic [REG_IDX_W-1:0]  rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    // Register-file write port
    output logic                  wb_en,
    output logic [REG_IDX_W-1:0]  wb_rd,
    output logic [ARCH_WIDTH-1:0] wb_data,
    output logic                  fifo_empty
`ifdef GPR_WB_FWD_EN
    ,
    output logic                  fwd1_hit,
    output logic                  fwd2_hit,
    output logic [ARCH_WIDTH-1:0] fwd_data
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    wb_entry_t              fifo_wdata;
    wb_entry_t              fifo_head;
    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_full;
    logic                   fifo_push;
    logic                   fifo_pop;

    wb_src_e                wb_src;
    logic [REG_IDX_W-1:0]   win_rd;
    logic [ARCH_WIDTH-1:0]  win_data;

    logic                   wb_en_q;
    logic [REG_IDX_W-1:0]   wb_rd_q;
    logic [ARCH_WIDTH-1:0]  wb_data_q;

    logic [REG_COUNT-1:0]   pending_q, pending_d;

    // Ready comes from registered occupancy only, so a full FIFO never pops through
    assign lsu_ready        = !fifo_full;
    assign fifo_push        = lsu_valid && lsu_ready;
    assign fifo_wdata.rd    = lsu_rd;
    assign fifo_wdata.data  = lsu_data;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_wb_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Pick at most one writer: a full FIFO takes priority so LSU producers can drain
    always_comb begin
        wb_src   = WB_SRC_NONE;
        fifo_pop = 1'b0;
        if (fifo_count == CNT_W'(FIFO_DEPTH)) begin
            wb_src   = WB_SRC_LSU;
            fifo_pop = 1'b1;
        end else if (alu_valid) begin
            wb_src   = WB_SRC_ALU;
        end else if (!fifo_empty) begin
            wb_src   = WB_SRC_LSU;
            fifo_pop = 1'b1;
        end
    end

    // Route the winning result towards the output register
    always_comb begin
        win_rd   = '0;
        win_data = '0;
        unique case (wb_src)
            WB_SRC_ALU: begin
                win_rd   = alu_rd;
                win_data = alu_data;
            end
            WB_SRC_LSU: begin
                win_rd   = fifo_head.rd;
                win_data = fifo_head.data;
            end
            default: begin
                win_rd   = '0;
                win_data = '0;
            end
        endcase
    end

    // The ALU holds its result whenever it did not win the port
    assign alu_stall = alu_valid && (wb_src != WB_SRC_ALU);

    // Register the winner; writes to x0 are consumed but never strobe wb_en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else if (wb_src != WB_SRC_NONE) begin
            wb_en_q   <= is_real_dest(win_rd);
            wb_rd_q   <= win_rd;
            wb_data_q <= win_data;
        end else begin
            wb_en_q   <= 1'b0;
        end
    end

    assign wb_en   = wb_en_q;
    assign wb_rd   = wb_rd_q;
    assign wb_data = wb_data_q;

    // Pending-write bits: FIFO pops clear, issues set afterwards so set wins on a tie
    always_comb begin
        pending_d = pending_q;
        if (fifo_pop) begin
            pending_d[fifo_head.rd] = 1'b0;
        end
        if (issue_valid) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Scoreboard state; reset drops every outstanding pending bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign rs1_busy = pending_q[rs1];
    assign rs2_busy = pending_q[rs2];

`ifdef GPR_WB_FWD_EN
    // Bypass the register file during the cycle the write is being performed
    assign fwd1_hit = wb_en_q && (wb_rd_q == rs1) && is_real_dest(wb_rd_q);
    assign fwd2_hit = wb_en_q && (wb_rd_q == rs2) && is_real_dest(wb_rd_q);
    assign fwd_data = wb_data_q;
`endif

endmodule

// File: tb/tb_gpr_writeback.sv
// Self-checking bench for gpr_writeback: directed scenarios plus randomized traffic,
// compared against a queue/bit-array reference model of the write-back rules.
module tb_gpr_writeback;
    import gpr_wb_pkg::*;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned AW         = 64;

    logic          clk;
    logic          rst_n;
    logic          alu_valid;
    logic [4:0]    alu_rd;
    logic [AW-1:0] alu_data;
    logic          alu_stall;
    logic          lsu_valid;
    logic          lsu_ready;
    logic [4:0]    lsu_rd;
    logic [AW-1:0] lsu_data;
    logic          issue_valid;
    logic [4:0]    issue_rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic          rs1_busy;
    logic          rs2_busy;
    logic          wb_en;
    logic [4:0]    wb_rd;
    logic [AW-1:0] wb_data;
    logic          fifo_empty;
`ifdef GPR_WB_FWD_EN
    logic          fwd1_hit;
    logic          fwd2_hit;
    logic [AW-1:0] fwd_data;
`endif

    gpr_writeback #(
        .ARCH_WIDTH (AW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_stall   (alu_stall),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .fifo_empty  (fifo_empty)
`ifdef GPR_WB_FWD_EN
        ,
        .fwd1_hit    (fwd1_hit),
        .fwd2_hit    (fwd2_hit),
        .fwd_data    (fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    wb_entry_t     mq[$];
    logic [31:0]   mpend;
    logic          mwb_en;
    logic [4:0]    mwb_rd;
    logic [AW-1:0] mwb_data;
    bit            alu_hold;
    bit            last_push;

    task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpend    = '0;
        mwb_en   = 1'b0;
        mwb_rd   = '0;
        mwb_data = '0;
        alu_hold = 1'b0;
        last_push = 1'b0;
    endtask

    task automatic idle_inputs();
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_data    = '0;
        lsu_valid   = 1'b0;
        lsu_rd      = '0;
        lsu_data    = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        rs1         = '0;
        rs2         = '0;
    endtask

    // Called at posedge+1 with inputs set: check combinational outputs, advance the
    // model by one cycle, then check the registered write port after the edge.
    task automatic step();
        bit        full;
        bit        pop;
        wb_entry_t e;
        full = (mq.size() == FIFO_DEPTH);
        #3;
        check("lsu_ready", lsu_ready, !full);
        check("alu_stall", alu_stall, alu_valid && full);
        check("fifo_empty", fifo_empty, mq.size() == 0);
        check("rs1_busy", rs1_busy, mpend[rs1]);
        check("rs2_busy", rs2_busy, mpend[rs2]);
`ifdef GPR_WB_FWD_EN
        check("fwd1_hit", fwd1_hit, mwb_en && (mwb_rd == rs1) && (mwb_rd != 0));
        check("fwd2_hit", fwd2_hit, mwb_en && (mwb_rd == rs2) && (mwb_rd != 0));
        if (mwb_en) check("fwd_data", fwd_data, mwb_data);
`endif
        pop = full || (!alu_valid && mq.size() != 0);
        if (pop) begin
            e = mq.pop_front();
            mwb_en   = (e.rd != 0);
            mwb_rd   = e.rd;
            mwb_data = e.data;
            mpend[e.rd] = 1'b0;
        end else if (alu_valid) begin
            mwb_en   = (alu_rd != 0);
            mwb_rd   = alu_rd;
            mwb_data = alu_data;
        end else begin
            mwb_en = 1'b0;
        end
        last_push = lsu_valid && !full;
        if (last_push) begin
            e.rd   = lsu_rd;
            e.data = lsu_data;
            mq.push_back(e);
        end
        if (issue_valid && issue_rd != 0) mpend[issue_rd] = 1'b1;
        alu_hold = alu_valid && full;
        @(posedge clk);
        #1;
        check("wb_en", wb_en, mwb_en);
        if (mwb_en) begin
            check("wb_rd", wb_rd, mwb_rd);
            check("wb_data", wb_data, mwb_data);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  pushed;
        bit  saw_full;
        logic [AW-1:0] alu_seq;

        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb_en_in", wb_en, 0);
        rst_n = 1'b1;
        #1;
        check("rst_wb_en", wb_en, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_fifo_empty", fifo_empty, 1);
        check("rst_lsu_ready", lsu_ready, 1);
        check("rst_alu_stall", alu_stall, 0);
        check("rst_rs1_busy", rs1_busy, 0);
        @(posedge clk);
        #1;

        // ALU only
        alu_valid = 1'b1; alu_rd = 5; alu_data = 64'hDEAD;
        step();
        check("alu_wb_rd5", wb_rd, 5);
        check("alu_wb_dead", wb_data, 64'hDEAD);
        alu_rd = 0; alu_data = 64'h55;
        step();
        check("alu_rd0_no_en", wb_en, 0);
        idle_inputs();

        // Scoreboard set, LSU push and clearing pop
        issue_valid = 1'b1; issue_rd = 7; rs1 = 7;
        step();
        issue_valid = 1'b0;
        check("sb_set", rs1_busy, 1);
        lsu_valid = 1'b1; lsu_rd = 7; lsu_data = 64'h1234;
        step();
        lsu_valid = 1'b0;
        check("sb_held_after_push", rs1_busy, 1);
        step();
        check("sb_lsu_en", wb_en, 1);
        check("sb_lsu_rd", wb_rd, 7);
        check("sb_lsu_data", wb_data, 64'h1234);
        check("sb_cleared", rs1_busy, 0);

        // Contention: ALU rd 9 stays valid while four LSU results arrive
        pushed = 0; saw_full = 0; alu_seq = 64'h900;
        alu_valid = 1'b1; alu_rd = 9;
        for (int i = 0; i < 12; i++) begin
            if (!alu_hold) begin
                alu_seq++;
                alu_data = alu_seq;
            end
            lsu_valid = (pushed < 4);
            lsu_rd    = 5'(pushed + 1);
            lsu_data  = 64'hA000 + 64'(pushed);
            step();
            if (last_push) pushed++;
            if (alu_stall && !lsu_ready) saw_full = 1;
        end
        lsu_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!alu_hold) alu_valid = 1'b0;
            step();
        end
        check("cont_pushed", 64'(pushed), 4);
        check("cont_saw_full", saw_full, 1);
        check("cont_drained", fifo_empty, 1);
        idle_inputs();

        // Same-cycle set and clear of rd 3: set wins
        issue_valid = 1'b1; issue_rd = 3;
        step();
        issue_valid = 1'b0;
        lsu_valid = 1'b1; lsu_rd = 3; lsu_data = 64'h33;
        step();
        lsu_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 3;
        step();
        issue_valid = 1'b0;
        rs1 = 3;
        #1;
        check("sb_set_wins_wb", wb_rd, 3);
        check("sb_set_wins", rs1_busy, 1);
        step();

`ifdef GPR_WB_FWD_EN
        alu_valid = 1'b1; alu_rd = 6; alu_data = 64'h6666;
        step();
        alu_valid = 1'b0; rs2 = 6;
        #1;
        check("fwd2_hit_rd6", fwd2_hit, 1);
        check("fwd_data_rd6", fwd_data, 64'h6666);
        alu_valid = 1'b1; alu_rd = 0; rs2 = 0;
        step();
        alu_valid = 1'b0;
        check("fwd2_hit_rd0", fwd2_hit, 0);
`endif
        idle_inputs();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (!alu_hold) begin
                alu_valid = ($urandom_range(0, 9) < 5);
                alu_rd    = 5'($urandom);
                alu_data  = {$urandom, $urandom};
            end
            lsu_valid   = ($urandom_range(0, 9) < 6);
            lsu_rd      = 5'($urandom);
            lsu_data    = {$urandom, $urandom};
            issue_valid = ($urandom_range(0, 9) < 3);
            issue_rd    = 5'($urandom);
            rs1         = ($urandom_range(0, 1) == 0) ? lsu_rd : 5'($urandom);
            rs2         = 5'($urandom);
            step();
        end
        idle_inputs();

        // Mid-stream reset with three queued entries and pending bits
        alu_valid = 1'b1; alu_rd = 10; alu_data = 64'h10;
        for (int i = 0; i < 3; i++) begin
            lsu_valid   = 1'b1;
            lsu_rd      = 5'(11 + i);
            lsu_data    = 64'hB0 + 64'(i);
            issue_valid = 1'b1;
            issue_rd    = 5'(11 + i);
            step();
        end
        idle_inputs();
        check("mid_fifo_not_empty", fifo_empty, 0);
        rs1 = 11;
        rst_n = 1'b0;
        #1;
        check("mid_rst_fifo_empty", fifo_empty, 1);
        check("mid_rst_wb_en", wb_en, 0);
        check("mid_rst_rs1_busy", rs1_busy, 0);
        check("mid_rst_lsu_ready", lsu_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        alu_valid = 1'b1; alu_rd = 5; alu_data = 64'hBEEF;
        step();
        check("post_rst_en", wb_en, 1);
        check("post_rst_data", wb_data, 64'hBEEF);
        idle_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
